// File: rtl/usb3_lfps_pkg.sv
// Shared encodings and default timing for the USB3 LFPS transmitter.
// Times are local_clk cycles at 125 MHz.
package usb3_lfps_pkg;

  typedef enum logic [1:0] {
    LFPS_POLL   = 2'd0,
    LFPS_PING   = 2'd1,
    LFPS_WRESET = 2'd2,
    LFPS_UEXIT  = 2'd3
  } lfps_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } lfps_state_e;

  localparam int unsigned DEF_T_BURST_POLL  = 125;
  localparam int unsigned DEF_T_REPEAT_POLL = 1250;
  localparam int unsigned DEF_T_BURST_PING  = 13;
  localparam int unsigned DEF_T_RESET       = 10000000;
  localparam int unsigned DEF_T_UEXIT_MIN   = 80;
  localparam int unsigned DEF_T_UEXIT_TO    = 250000;
  localparam int unsigned DEF_CNT_W         = 24;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/usb3_sync2.sv
// Two-flop single-bit synchroniser; the input is a level from another clock domain.
module usb3_sync2 (
  input  logic local_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge local_clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb3_lfps_tx.sv
// LFPS burst generator driving the PIPE tx_elecidle/tx_oneszeros pair for
// Polling.LFPS, Ping, Warm Reset and U-state exit signalling.
module usb3_lfps_tx
  import usb3_lfps_pkg::*;
#(
  parameter int unsigned T_BURST_POLL  = DEF_T_BURST_POLL,
  parameter int unsigned T_REPEAT_POLL = DEF_T_REPEAT_POLL,
  parameter int unsigned T_BURST_PING  = DEF_T_BURST_PING,
  parameter int unsigned T_RESET       = DEF_T_RESET,
  parameter int unsigned T_UEXIT_MIN   = DEF_T_UEXIT_MIN,
  parameter int unsigned T_UEXIT_TO    = DEF_T_UEXIT_TO,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       local_clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_type,
  output logic       cmd_ready,
  input  logic       cmd_stop,
  input  logic       partner_lfps,
  output logic       tx_elecidle,
  output logic       tx_oneszeros,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] burst_count
);

  // Terminal timer values: a phase of N cycles ends while the timer reads N-1.
  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(T_BURST_POLL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_REPEAT_POLL - T_BURST_POLL - 1);
  localparam logic [CNT_W-1:0] PING_LAST  = CNT_W'(T_BURST_PING - 1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] UEXIT_MIN  = CNT_W'(T_UEXIT_MIN);
  localparam logic [CNT_W-1:0] UEXIT_LAST = CNT_W'(T_UEXIT_TO - 1);

  lfps_state_e      state;
  lfps_cmd_e        cmd_q;
  logic [CNT_W-1:0] timer;
  logic             stop_pend;
  logic             partner_sync;
  logic             accept;
  logic             poll_last;
  logic             fin_ok;
  logic             fin_to;

  usb3_sync2 u_partner_sync (
    .local_clk (local_clk),
    .reset     (reset),
    .d         (partner_lfps),
    .q         (partner_sync)
  );

  assign accept    = cmd_valid & cmd_ready;
  assign poll_last = (timer == POLL_LAST);

  // Burst termination for the latched command; a POLL burst that ends without a stop goes to GAP.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fin_ok = 1'b0;
    fin_to = 1'b0;
    case (cmd_q)
      LFPS_POLL:   fin_ok = poll_last && (stop_pend || cmd_stop);
      LFPS_PING:   fin_ok = (timer == PING_LAST);
      LFPS_WRESET: fin_ok = cmd_stop || (timer == RESET_LAST);
      LFPS_UEXIT: begin
        fin_ok = partner_sync && (timer >= UEXIT_MIN);
        fin_to = !fin_ok && (timer == UEXIT_LAST);
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; later assignments in the block override defaults.
  always_ff @(posedge local_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cmd_q        <= LFPS_POLL;
      timer        <= '0;
      stop_pend    <= 1'b0;
      tx_elecidle  <= 1'b1;
      tx_oneszeros <= 1'b0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      burst_count  <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      timer   <= timer + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (accept) begin
            state        <= ST_BURST;
            cmd_q        <= lfps_cmd_e'(cmd_type);
            burst_count  <= '0;
            stop_pend    <= 1'b0;
            tx_elecidle  <= 1'b0;
            tx_oneszeros <= 1'b1;
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
          end
        end

        ST_BURST: begin
          // A POLL stop during a burst is remembered so the burst still runs to full length.
          if (cmd_q == LFPS_POLL && cmd_stop) begin
            stop_pend <= 1'b1;
          end
          if (cmd_q == LFPS_POLL && poll_last) begin
            burst_count <= sat_inc8(burst_count);
          end
          if (fin_ok || fin_to) begin
            state        <= ST_IDLE;
            timer        <= '0;
            tx_elecidle  <= 1'b1;
            tx_oneszeros <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= fin_ok;
            timeout      <= fin_to;
          end else if (cmd_q == LFPS_POLL && poll_last) begin
            state        <= ST_GAP;
            timer        <= '0;
            tx_elecidle  <= 1'b1;
            tx_oneszeros <= 1'b0;
          end
        end

        ST_GAP: begin
          if (cmd_stop) begin
            state        <= ST_IDLE;
            timer        <= '0;
            tx_elecidle  <= 1'b1;
            tx_oneszeros <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else if (timer == GAP_LAST) begin
            state        <= ST_BURST;
            timer        <= '0;
            tx_elecidle  <= 1'b0;
            tx_oneszeros <= 1'b1;
          end
        end

        default: begin
          state        <= ST_IDLE;
          timer        <= '0;
          tx_elecidle  <= 1'b1;
          tx_oneszeros <= 1'b0;
          cmd_ready    <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb3_lfps_tx.sv
// Directed bench for usb3_lfps_tx with shortened timing; expected waveforms are hand-derived.
module tb_usb3_lfps_tx;

  logic       local_clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'd0;
  logic       cmd_ready;
  logic       cmd_stop = 1'b0;
  logic       partner_lfps = 1'b0;
  logic       tx_elecidle;
  logic       tx_oneszeros;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] burst_count;

  int checks = 0;
  int failures = 0;

  usb3_lfps_tx #(
    .T_BURST_POLL  (4),
    .T_REPEAT_POLL (10),
    .T_BURST_PING  (3),
    .T_RESET       (20),
    .T_UEXIT_MIN   (5),
    .T_UEXIT_TO    (30),
    .CNT_W         (24)
  ) dut (
    .local_clk    (local_clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_type     (cmd_type),
    .cmd_ready    (cmd_ready),
    .cmd_stop     (cmd_stop),
    .partner_lfps (partner_lfps),
    .tx_elecidle  (tx_elecidle),
    .tx_oneszeros (tx_oneszeros),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .burst_count  (burst_count)
  );

  always #4 local_clk = ~local_clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge local_clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Issue a one-cycle command; on return the DUT has taken the accept edge.
  task automatic issue(input logic [1:0] t);
    cmd_type  = t;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
    step();
    checks++;
    if ({tx_elecidle, tx_oneszeros, cmd_ready, busy, done, timeout} !== 6'b101000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=101000",
               {tx_elecidle, tx_oneszeros, cmd_ready, busy, done, timeout});
    end
    checks++;
    if (burst_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", burst_count);
    end
  endtask

  // Bursts of 4 low / gaps of 6 high; stop raised in the first cycle of the 3rd burst.
  task automatic test_poll();
    logic exp_idle;
    issue(2'd0);
    for (int i = 0; i < 24; i++) begin
      if (i > 0) step();
      exp_idle = ((i % 10) >= 4);
      checks++;
      if (tx_elecidle !== exp_idle || tx_oneszeros !== !exp_idle || done !== 1'b0) begin
        failures++;
        $display("FAIL poll_wave i=%0d got=%b%b%b exp=%b%b0", i, tx_elecidle, tx_oneszeros, done,
                 exp_idle, !exp_idle);
      end
      if (i == 10 || i == 20) begin
        checks++;
        if (burst_count !== 8'(i / 10)) begin
          failures++;
          $display("FAIL poll_count_mid i=%0d got=%0d exp=%0d", i, burst_count, i / 10);
        end
      end
      if (i == 20) cmd_stop = 1'b1;
      if (i == 21) cmd_stop = 1'b0;
    end
    step();
    checks++;
    if ({tx_elecidle, done, cmd_ready, busy} !== 4'b1110 || burst_count !== 8'd3) begin
      failures++;
      $display("FAIL poll_end got=%b cnt=%0d exp=1110 cnt=3",
               {tx_elecidle, done, cmd_ready, busy}, burst_count);
    end
    step();
    checks++;
    if (done !== 1'b0 || burst_count !== 8'd3 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL poll_after got done=%b cnt=%0d rdy=%b exp done=0 cnt=3 rdy=1",
               done, burst_count, cmd_ready);
    end
  endtask

  task automatic test_ping();
    issue(2'd1);
    cmd_stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++;
      if (tx_elecidle !== (i >= 3) || done !== (i == 3)) begin
        failures++;
        $display("FAIL ping_wave i=%0d got idle=%b done=%b exp idle=%b done=%b",
                 i, tx_elecidle, done, (i >= 3), (i == 3));
      end
    end
    cmd_stop = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ping_after got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_warm_reset();
    issue(2'd2);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      checks++;
      if (tx_elecidle !== 1'b0) begin
        failures++;
        $display("FAIL wreset_stop_wave i=%0d got=%b exp=0", i, tx_elecidle);
      end
    end
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
    checks++;
    if (tx_elecidle !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL wreset_stop_end got idle=%b done=%b exp 1 1", tx_elecidle, done);
    end
    idle_cycles(2);
    issue(2'd2);
    for (int i = 0; i < 21; i++) begin
      if (i > 0) step();
      checks++;
      if (tx_elecidle !== (i >= 20) || done !== (i == 20)) begin
        failures++;
        $display("FAIL wreset_full i=%0d got idle=%b done=%b exp idle=%b done=%b",
                 i, tx_elecidle, done, (i >= 20), (i == 20));
      end
    end
  endtask

  // Partner pulse during burst cycles 2-3 reaches the FSM below T_UEXIT_MIN and must be ignored;
  // the second rise (burst cycle 10) ends the burst after the 2-flop delay.
  task automatic test_uexit();
    issue(2'd3);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) step();
      checks++;
      if (tx_elecidle !== (i >= 12) || done !== (i == 12) || timeout !== 1'b0) begin
        failures++;
        $display("FAIL uexit_ok i=%0d got idle=%b done=%b to=%b exp idle=%b done=%b to=0",
                 i, tx_elecidle, done, timeout, (i >= 12), (i == 12));
      end
      if (i == 1) partner_lfps = 1'b1;
      if (i == 3) partner_lfps = 1'b0;
      if (i == 9) partner_lfps = 1'b1;
    end
    partner_lfps = 1'b0;
    idle_cycles(3);
    issue(2'd3);
    for (int i = 0; i < 31; i++) begin
      if (i > 0) step();
      checks++;
      if (tx_elecidle !== (i >= 30) || timeout !== (i == 30) || done !== 1'b0) begin
        failures++;
        $display("FAIL uexit_to i=%0d got idle=%b to=%b done=%b exp idle=%b to=%b done=0",
                 i, tx_elecidle, timeout, done, (i >= 30), (i == 30));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    issue(2'd0);
    idle_cycles(11);
    checks++;
    if (tx_elecidle !== 1'b0 || burst_count !== 8'd1) begin
      failures++;
      $display("FAIL rmid_pre got idle=%b cnt=%0d exp 0 1", tx_elecidle, burst_count);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({tx_elecidle, tx_oneszeros, busy, cmd_ready} !== 4'b1001 || burst_count !== 8'd0) begin
      failures++;
      $display("FAIL rmid_post got=%b cnt=%0d exp=1001 cnt=0",
               {tx_elecidle, tx_oneszeros, busy, cmd_ready}, burst_count);
    end
    reset = 1'b0;
    step();
  endtask

  // Accept coincides with stop (ignored); cmd_valid stays high while busy and must not re-accept.
  task automatic test_back_to_back();
    cmd_type  = 2'd0;
    cmd_valid = 1'b1;
    cmd_stop  = 1'b1;
    step();
    cmd_stop = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) step();
      checks++;
      if (tx_elecidle !== ((i % 10) >= 4) || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_wave i=%0d got idle=%b busy=%b rdy=%b exp idle=%b busy=1 rdy=0",
                 i, tx_elecidle, busy, cmd_ready, ((i % 10) >= 4));
      end
    end
    cmd_valid = 1'b0;
    cmd_stop  = 1'b1;
    step();
    cmd_stop = 1'b0;
    checks++;
    if (done !== 1'b1 || burst_count !== 8'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got done=%b cnt=%0d busy=%b exp 1 2 0", done, burst_count, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || tx_elecidle !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle got busy=%b idle=%b exp 0 1", busy, tx_elecidle);
    end
  endtask

  task automatic test_count_saturate();
    bit seen_done = 1'b0;
    issue(2'd0);
    idle_cycles(2600);
    checks++;
    if (burst_count !== 8'hFF) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=255", burst_count);
    end
    cmd_stop = 1'b1;
    for (int i = 0; i < 12 && !seen_done; i++) begin
      step();
      seen_done = done;
    end
    cmd_stop = 1'b0;
    checks++;
    if (!seen_done || burst_count !== 8'hFF) begin
      failures++;
      $display("FAIL sat_done got done_seen=%b cnt=%0d exp 1 255", seen_done, burst_count);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_poll();
    idle_cycles(2);
    test_ping();
    idle_cycles(2);
    test_warm_reset();
    idle_cycles(2);
    test_uexit();
    idle_cycles(3);
    test_reset_mid_burst();
    test_back_to_back();
    idle_cycles(2);
    test_count_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
